sm83_dma_arb: RTL and testbench

SM83_DMA_ARB -- requirements
Module: sm83_dma_arb

---
 rtl/sm83_dma_arb_if.sv | 44 ++++
 rtl/sm83_dma_arb.sv | 130 +++++++++++++
 tb/tb_sm83_dma_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_dma_arb_if.sv
// -----------------------------------------------------------------------------
// sm83_dma_arb_if
// Bundles the bus signals around the SM83 OAM DMA arbiter: the CPU-side
// request/response, the shared ROM/WRAM bus, the OAM write port and the
// DMA busy flag.
//
// Signals:
//   cpu_addr/cpu_wdata/cpu_wen : CPU access request (read when cpu_wen=0)
//   cpu_rdata                  : read data returned to the CPU, same cycle
//   mem_addr/mem_wdata/mem_wen : shared ROM/WRAM bus driven by the arbiter
//   mem_rdata                  : shared-bus read data, combinational
//   oam_addr/oam_wdata/oam_wen : OAM write port
//   dma_active                 : high while a transfer is in progress
//
// Modports:
//   master : the arbiter, which owns the shared bus and the OAM port
//   slave  : the surrounding CPU / memory / OAM environment
// -----------------------------------------------------------------------------
interface sm83_dma_arb_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wen;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wen;
   logic [7:0]  mem_rdata;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_wen;
   logic        dma_active;

   modport master (
      input  cpu_addr, cpu_wdata, cpu_wen, mem_rdata,
      output cpu_rdata, mem_addr, mem_wdata, mem_wen,
      output oam_addr, oam_wdata, oam_wen, dma_active
   );

   modport slave (
      output cpu_addr, cpu_wdata, cpu_wen, mem_rdata,
      input  cpu_rdata, mem_addr, mem_wdata, mem_wen,
      input  oam_addr, oam_wdata, oam_wen, dma_active
   );
endinterface

// File: rtl/sm83_dma_arb.sv
// -----------------------------------------------------------------------------
// sm83_dma_arb
// OAM DMA engine and CPU/DMA arbiter for the shared ROM/WRAM bus.
// A CPU write to DMA_REG_ADDR latches a source page and starts a transfer
// of DMA_LEN bytes from {page, 8'h00} into OAM. While a transfer runs the
// CPU is locked off the shared bus: reads return 8'hFF and writes are
// dropped. The DMA register itself stays readable at all times.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sm83_dma_arb_if.master (CPU, shared memory, OAM, dma_active)
// -----------------------------------------------------------------------------
module sm83_dma_arb #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter int          DMA_LEN      = 160
) (
   input  logic             clk,
   input  logic             rst,
   sm83_dma_arb_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      COPY  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] page_q;
   logic [7:0] idx;
   logic [7:0] data_q;
   logic [7:0] idx_q;
   logic       wr_pend;

   logic       reg_hit;
   logic       trigger;
   logic [7:0] eff_page;

   assign reg_hit = (bus.cpu_addr == DMA_REG_ADDR);
   assign trigger = reg_hit && bus.cpu_wen;

   // Pages E0..FF are the echo of C0..DF, so source from the real WRAM page.
   assign eff_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

   // State, source page and the one-stage read-to-write pipeline.
   // A trigger clears wr_pend so the read performed in the trigger cycle is
   // discarded; a write already pending (wr_pend=1 now) still completes this
   // cycle because oam_wen is driven straight from the register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         page_q  <= 8'h00;
         idx     <= 8'h00;
         data_q  <= 8'h00;
         idx_q   <= 8'h00;
         wr_pend <= 1'b0;
      end else begin
         state <= state_next;
         if (trigger) begin
            page_q  <= bus.cpu_wdata;
            idx     <= 8'h00;
            wr_pend <= 1'b0;
         end else if (state == COPY) begin
            data_q  <= bus.mem_rdata;
            idx_q   <= idx;
            idx     <= idx + 8'd1;
            wr_pend <= 1'b1;
         end else begin
            wr_pend <= 1'b0;
         end
      end
   end

   // Next-state logic; a register write restarts from any state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = IDLE;
         START:   state_next = COPY;
         COPY:    state_next = (idx == LAST_IDX) ? DRAIN : COPY;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (trigger) begin
         state_next = START;
      end
   end

   // Bus steering: the CPU owns the shared bus only in IDLE, and a write to
   // the DMA register never leaks onto it.
   always_comb begin
      bus.mem_addr  = 16'h0000;
      bus.mem_wdata = 8'h00;
      bus.mem_wen   = 1'b0;
      case (state)
         IDLE: begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wen   = bus.cpu_wen && !reg_hit;
         end
         COPY: begin
            bus.mem_addr = {eff_page, idx};
         end
         default: begin
            bus.mem_addr = 16'h0000;
         end
      endcase
   end

   // CPU read data: register always visible, bus locked out while busy.
   always_comb begin
      bus.cpu_rdata = bus.mem_rdata;
      if (reg_hit) begin
         bus.cpu_rdata = page_q;
      end else if (state != IDLE) begin
         bus.cpu_rdata = 8'hFF;
      end
   end

   assign bus.oam_wen    = wr_pend;
   assign bus.oam_addr   = idx_q;
   assign bus.oam_wdata  = data_q;
   assign bus.dma_active = (state != IDLE);

endmodule

// File: tb/tb_sm83_dma_arb.sv
// -----------------------------------------------------------------------------
// tb_sm83_dma_arb
// Directed bench for sm83_dma_arb. A 64 KiB memory model answers the shared
// bus; expected OAM writes are queued when a transfer is started and popped
// by a monitor whenever the arbiter pulses oam_wen.
// -----------------------------------------------------------------------------
module tb_sm83_dma_arb;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } oam_wr_t;

   logic clk = 1'b0;
   logic rst;

   logic [7:0] mem [0:65535];
   logic [7:0] oam [0:255];

   oam_wr_t expQ[$];
   oam_wr_t monEntry;

   int checks    = 0;
   int failures  = 0;
   int oamPulses = 0;

   sm83_dma_arb_if bus();

   sm83_dma_arb #(
      .DMA_REG_ADDR (16'hFF46),
      .DMA_LEN      (160)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory and OAM models.
   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_wen === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.oam_wen === 1'b1) oam[bus.oam_addr] <= bus.oam_wdata;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: every OAM write must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.oam_wen === 1'b1) begin
         oamPulses++;
         if (expQ.size() == 0) begin
            checkOutput("oam_unexpected_wen", 16'(bus.oam_wen), 16'h0000);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("oam_addr", 16'(bus.oam_addr), 16'(monEntry.a));
            checkOutput("oam_data", 16'(bus.oam_wdata), 16'(monEntry.d));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_wen   = w;
      #1;
   endtask

   task automatic pushExpected(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         expQ.push_back({8'(i), 8'(i) ^ 8'h5A});
      end
   endtask

   // Trigger cycle, then the single START cycle.
   task automatic startDma(input logic [7:0] page);
      applyStimulus(16'hFF46, page, 1'b1);
      checkOutput("trig_mem_wen", 16'(bus.mem_wen), 16'h0000);
      step();
      oamPulses = 0;
      applyStimulus(16'h0000, 8'h00, 1'b0);
      checkOutput("start_active", 16'(bus.dma_active), 16'h0001);
      checkOutput("start_mem_addr", bus.mem_addr, 16'h0000);
      checkOutput("start_mem_wen", 16'(bus.mem_wen), 16'h0000);
      checkOutput("start_oam_wen", 16'(bus.oam_wen), 16'h0000);
   endtask

   task automatic copyCycles(input logic [7:0] srcPage, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         step();
         checkOutput("copy_mem_addr", bus.mem_addr, {srcPage, 8'(i)});
         checkOutput("copy_mem_wen", 16'(bus.mem_wen), 16'h0000);
      end
   endtask

   task automatic drainAndIdle();
      step();
      checkOutput("drain_active", 16'(bus.dma_active), 16'h0001);
      checkOutput("drain_mem_addr", bus.mem_addr, 16'h0000);
      checkOutput("drain_oam_wen", 16'(bus.oam_wen), 16'h0001);
      step();
      checkOutput("idle_active", 16'(bus.dma_active), 16'h0000);
      checkOutput("idle_oam_wen", 16'(bus.oam_wen), 16'h0000);
      checkOutput("oam_pulse_count", 16'(oamPulses), 16'd160);
      checkOutput("queue_empty", 16'(expQ.size()), 16'h0000);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5A;
      for (int a = 0; a < 256; a++) oam[a] = 8'h00;

      // Reset state.
      rst = 1'b1;
      applyStimulus(16'h0000, 8'h00, 1'b0);
      step();
      step();
      rst = 1'b0;
      step();
      applyStimulus(16'hFF46, 8'h00, 1'b0);
      checkOutput("rst_page_read", 16'(bus.cpu_rdata), 16'h0000);
      checkOutput("rst_active", 16'(bus.dma_active), 16'h0000);
      checkOutput("rst_oam_wen", 16'(bus.oam_wen), 16'h0000);
      checkOutput("rst_oam_addr", 16'(bus.oam_addr), 16'h0000);
      checkOutput("rst_oam_wdata", 16'(bus.oam_wdata), 16'h0000);
      checkOutput("rst_mem_addr", bus.mem_addr, 16'hFF46);

      // IDLE passthrough write then read back.
      step();
      applyStimulus(16'hC010, 8'hAB, 1'b1);
      checkOutput("pass_mem_wen", 16'(bus.mem_wen), 16'h0001);
      checkOutput("pass_mem_addr", bus.mem_addr, 16'hC010);
      checkOutput("pass_mem_wdata", 16'(bus.mem_wdata), 16'h00AB);
      step();
      applyStimulus(16'hC010, 8'h00, 1'b0);
      checkOutput("pass_read", 16'(bus.cpu_rdata), 16'h00AB);
      checkOutput("pass_read_wen", 16'(bus.mem_wen), 16'h0000);
      step();
      applyStimulus(16'hC010, 8'h4A, 1'b1);
      step();
      applyStimulus(16'hC010, 8'h00, 1'b0);
      checkOutput("pass_restore", 16'(bus.cpu_rdata), 16'h004A);
      step();

      // Full transfer from page C0 with CPU accesses during COPY.
      pushExpected(0, 159);
      startDma(8'hC0);
      for (int i = 0; i < 160; i++) begin
         step();
         case (i)
            5: begin
               applyStimulus(16'hC000, 8'h00, 1'b0);
               checkOutput("lock_read", 16'(bus.cpu_rdata), 16'h00FF);
            end
            6: begin
               applyStimulus(16'hC001, 8'h00, 1'b1);
               checkOutput("lock_write_wen", 16'(bus.mem_wen), 16'h0000);
            end
            7: begin
               applyStimulus(16'hFF46, 8'h00, 1'b0);
               checkOutput("busy_page_read", 16'(bus.cpu_rdata), 16'h00C0);
            end
            8: applyStimulus(16'h0000, 8'h00, 1'b0);
            default: ;
         endcase
         checkOutput("copy_mem_addr", bus.mem_addr, {8'hC0, 8'(i)});
      end
      drainAndIdle();
      checkOutput("wram1_kept", 16'(mem[16'hC001]), 16'h005B);
      for (int i = 0; i < 160; i++) begin
         checkOutput("oam_content", 16'(oam[i]), 16'(8'(i) ^ 8'h5A));
      end

      // Echo page E1 sources from C1.
      pushExpected(0, 159);
      startDma(8'hE1);
      copyCycles(8'hC1, 0, 159);
      drainAndIdle();

      // Restart mid-transfer at idx 50.
      pushExpected(0, 49);
      startDma(8'hC0);
      copyCycles(8'hC0, 0, 49);
      step();
      checkOutput("restart_mem_addr", bus.mem_addr, 16'hC032);
      checkOutput("inflight_wen", 16'(bus.oam_wen), 16'h0001);
      checkOutput("inflight_addr", 16'(bus.oam_addr), 16'd49);
      checkOutput("inflight_data", 16'(bus.oam_wdata), 16'(8'd49 ^ 8'h5A));
      pushExpected(0, 159);
      startDma(8'hC1);
      copyCycles(8'hC1, 0, 159);
      drainAndIdle();

      // Reset at idx 20 aborts.
      pushExpected(0, 19);
      startDma(8'hC0);
      copyCycles(8'hC0, 0, 19);
      step();
      checkOutput("abort_mem_addr", bus.mem_addr, 16'hC014);
      rst = 1'b1;
      applyStimulus(16'hFF46, 8'h00, 1'b0);
      step();
      checkOutput("abort_active", 16'(bus.dma_active), 16'h0000);
      checkOutput("abort_oam_wen", 16'(bus.oam_wen), 16'h0000);
      checkOutput("abort_page_read", 16'(bus.cpu_rdata), 16'h0000);
      rst = 1'b0;
      oamPulses = 0;
      repeat (5) step();
      checkOutput("abort_no_pulses", 16'(oamPulses), 16'h0000);
      checkOutput("abort_queue_empty", 16'(expQ.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
